// File: rtl/laser_score.sv
// laser_score: coverage checker for the LASER two-circle solver.
// Snoops the NPTS-point X/Y frame, latches both circle centres on the first
// DONE_IN after the frame is complete, then evaluates one buffered point per
// cycle and reports how many points lie inside the union of the two circles.
//
// Ports:
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   IN_VALID, X, Y    point stream; a point is stored each cycle IN_VALID=1 in CAPTURE
//   DONE_IN           solver done; centres C1X..C2Y are sampled on its first edge in WAIT_C
//   C1X, C1Y, C2X, C2Y circle centres
//   BUSY              high unless idle in CAPTURE with no points stored
//   SCORE             covered-point count, held until the next SCORE_VALID
//   SCORE_VALID       one-cycle pulse when SCORE updates
//   C1_CNT, C2_CNT    per-circle hit counts (only with LASER_SCORE_SPLIT_EN)
//
// Optional feature macro: LASER_SCORE_SPLIT_EN
module laser_score #(
  parameter int unsigned NPTS    = 40,
  parameter int unsigned COORD_W = 4,
  parameter int unsigned R2      = 16,
  parameter int unsigned CNT_W   = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  input  logic               DONE_IN,
  input  logic [COORD_W-1:0] C1X,
  input  logic [COORD_W-1:0] C1Y,
  input  logic [COORD_W-1:0] C2X,
  input  logic [COORD_W-1:0] C2Y,
  output logic               BUSY,
  output logic [CNT_W-1:0]   SCORE,
  output logic               SCORE_VALID
`ifdef LASER_SCORE_SPLIT_EN
  ,
  output logic [CNT_W-1:0]   C1_CNT,
  output logic [CNT_W-1:0]   C2_CNT
`endif
);

  localparam int unsigned SUM_W = 2 * COORD_W + 1;
  localparam int unsigned PT_W  = 2 * COORD_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPTS - 1);
  localparam logic [SUM_W-1:0] R2_V     = SUM_W'(R2);

  typedef enum logic [1:0] {CAPTURE, WAIT_C, EVAL, REPORT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   idx, idx_nxt;
  logic [CNT_W-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]   score_nxt;
  logic               score_valid_nxt, busy_nxt;
  logic [COORD_W-1:0] c1x_q, c1y_q, c2x_q, c2y_q;
  logic [COORD_W-1:0] c1x_nxt, c1y_nxt, c2x_nxt, c2y_nxt;
  logic [PT_W-1:0]    pbuf [NPTS];
  logic [PT_W-1:0]    cur_pt;
  logic               hit1, hit2, hit;
`ifdef LASER_SCORE_SPLIT_EN
  logic [CNT_W-1:0]   acc1, acc1_nxt, acc2, acc2_nxt;
  logic [CNT_W-1:0]   c1_cnt_nxt, c2_cnt_nxt;
`endif

  // Squared distance at full width: 15^2 + 15^2 = 450 needs all 9 bits.
  function automatic logic [SUM_W-1:0] dist2(input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py,
                                             input logic [COORD_W-1:0] cx, input logic [COORD_W-1:0] cy);
    logic [COORD_W-1:0] dx, dy;
    logic [SUM_W-1:0]   dxe, dye;
    dx  = (px >= cx) ? px - cx : cx - px;
    dy  = (py >= cy) ? py - cy : cy - py;
    dxe = SUM_W'(dx);
    dye = SUM_W'(dy);
    return dxe * dxe + dye * dye;
  endfunction

  // Point buffer; contents need no reset.
  always_ff @(posedge CLK) begin
    if (state == CAPTURE && IN_VALID) pbuf[idx] <= {X, Y};
  end

  assign cur_pt = pbuf[idx];
  assign hit1   = dist2(cur_pt[PT_W-1:COORD_W], cur_pt[COORD_W-1:0], c1x_q, c1y_q) <= R2_V;
  assign hit2   = dist2(cur_pt[PT_W-1:COORD_W], cur_pt[COORD_W-1:0], c2x_q, c2y_q) <= R2_V;
  assign hit    = hit1 | hit2;

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    acc_nxt         = acc;
    score_nxt       = SCORE;
    score_valid_nxt = 1'b0;
    c1x_nxt         = c1x_q;
    c1y_nxt         = c1y_q;
    c2x_nxt         = c2x_q;
    c2y_nxt         = c2y_q;
`ifdef LASER_SCORE_SPLIT_EN
    acc1_nxt        = acc1;
    acc2_nxt        = acc2;
    c1_cnt_nxt      = C1_CNT;
    c2_cnt_nxt      = C2_CNT;
`endif
    case (state)
      CAPTURE: begin
        if (IN_VALID) begin
          if (idx == LAST_IDX) begin
            state_nxt = WAIT_C;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + CNT_W'(1);
          end
        end
      end
      WAIT_C: begin
        if (DONE_IN) begin
          c1x_nxt   = C1X;
          c1y_nxt   = C1Y;
          c2x_nxt   = C2X;
          c2y_nxt   = C2Y;
          acc_nxt   = '0;
          idx_nxt   = '0;
`ifdef LASER_SCORE_SPLIT_EN
          acc1_nxt  = '0;
          acc2_nxt  = '0;
`endif
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        acc_nxt = acc + CNT_W'(hit);
`ifdef LASER_SCORE_SPLIT_EN
        acc1_nxt = acc1 + CNT_W'(hit1);
        acc2_nxt = acc2 + CNT_W'(hit2);
`endif
        if (idx == LAST_IDX) begin
          idx_nxt   = '0;
          state_nxt = REPORT;
        end else begin
          idx_nxt = idx + CNT_W'(1);
        end
      end
      REPORT: begin
        score_nxt       = acc;
        score_valid_nxt = 1'b1;
`ifdef LASER_SCORE_SPLIT_EN
        c1_cnt_nxt      = acc1;
        c2_cnt_nxt      = acc2;
`endif
        idx_nxt         = '0;
        state_nxt       = CAPTURE;
      end
      default: state_nxt = CAPTURE;
    endcase
    // Registered BUSY tracks the state being entered.
    busy_nxt = !(state_nxt == CAPTURE && idx_nxt == '0);
  end

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= CAPTURE;
      idx         <= '0;
      acc         <= '0;
      c1x_q       <= '0;
      c1y_q       <= '0;
      c2x_q       <= '0;
      c2y_q       <= '0;
      BUSY        <= 1'b0;
      SCORE       <= '0;
      SCORE_VALID <= 1'b0;
`ifdef LASER_SCORE_SPLIT_EN
      acc1        <= '0;
      acc2        <= '0;
      C1_CNT      <= '0;
      C2_CNT      <= '0;
`endif
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      acc         <= acc_nxt;
      c1x_q       <= c1x_nxt;
      c1y_q       <= c1y_nxt;
      c2x_q       <= c2x_nxt;
      c2y_q       <= c2y_nxt;
      BUSY        <= busy_nxt;
      SCORE       <= score_nxt;
      SCORE_VALID <= score_valid_nxt;
`ifdef LASER_SCORE_SPLIT_EN
      acc1        <= acc1_nxt;
      acc2        <= acc2_nxt;
      C1_CNT      <= c1_cnt_nxt;
      C2_CNT      <= c2_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_laser_score.sv
// tb_laser_score: self-checking bench for laser_score.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_laser_score;

  localparam int NPTS = 40;

  logic       CLK, RST, IN_VALID, DONE_IN;
  logic [3:0] X, Y, C1X, C1Y, C2X, C2Y;
  logic       BUSY, SCORE_VALID;
  logic [5:0] SCORE;
`ifdef LASER_SCORE_SPLIT_EN
  logic [5:0] C1_CNT, C2_CNT;
`endif

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;
  int exp_pulses = 0;
  logic [3:0] fx [NPTS];
  logic [3:0] fy [NPTS];

  typedef struct {
    logic [3:0] px, py, c1x, c1y, c2x, c2y;
    int         exp;
  } vec_t;

  laser_score dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .X(X), .Y(Y), .DONE_IN(DONE_IN),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .BUSY(BUSY), .SCORE(SCORE), .SCORE_VALID(SCORE_VALID)
`ifdef LASER_SCORE_SPLIT_EN
    , .C1_CNT(C1_CNT), .C2_CNT(C2_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Every cycle SCORE_VALID is high counts as one pulse cycle.
  always @(posedge CLK) if (SCORE_VALID) pulse_cnt <= pulse_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: count points inside either circle using plain integer geometry.
  task automatic model(input int c1x, input int c1y, input int c2x, input int c2y,
                       output int s, output int n1, output int n2);
    int d1, d2;
    s = 0; n1 = 0; n2 = 0;
    for (int i = 0; i < NPTS; i++) begin
      d1 = (int'(fx[i]) - c1x) ** 2 + (int'(fy[i]) - c1y) ** 2;
      d2 = (int'(fx[i]) - c2x) ** 2 + (int'(fy[i]) - c2y) ** 2;
      if (d1 <= 16) n1++;
      if (d2 <= 16) n2++;
      if (d1 <= 16 || d2 <= 16) s++;
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic send_points(input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          IN_VALID = 1'b0; X = 4'($urandom); Y = 4'($urandom);
          @(negedge CLK);
        end
      end
      IN_VALID = 1'b1; X = fx[i]; Y = fy[i];
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
  endtask

  task automatic finish_frame(input string name, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d,
                              input int exp, input int exp1, input int exp2,
                              input bit junk, input bit hold);
    int k;
    bit got;
    DONE_IN = 1'b1; C1X = a; C1Y = b; C2X = c; C2Y = d;
    @(negedge CLK);
    k = 0; got = 1'b0;
    while (!got && k < 100) begin
      if (!hold) DONE_IN = 1'b0;
      C1X = 4'($urandom); C1Y = 4'($urandom); C2X = 4'($urandom); C2Y = 4'($urandom);
      if (k == 20) check({name, " busy_eval"}, int'(BUSY), 1);
      if (SCORE_VALID) got = 1'b1;
      else begin
        if (junk && k == 40) begin IN_VALID = 1'b1; X = 4'd0; Y = 4'd0; end
        @(negedge CLK);
        k++;
      end
    end
    IN_VALID = 1'b0;
    check({name, " valid_seen"}, int'(got), 1);
    check({name, " latency"}, k, 41);
    check({name, " score"}, int'(SCORE), exp);
    check({name, " busy_idle"}, int'(BUSY), 0);
`ifdef LASER_SCORE_SPLIT_EN
    if (exp1 >= 0) check({name, " c1_cnt"}, int'(C1_CNT), exp1);
    if (exp2 >= 0) check({name, " c2_cnt"}, int'(C2_CNT), exp2);
`endif
    exp_pulses++;
  endtask

  task automatic check_pulses(input string name);
    repeat (3) @(negedge CLK);
    check({name, " pulse_count"}, pulse_cnt, exp_pulses);
  endtask

  initial begin
    vec_t vt[13];
    int s, n1, n2, cx, cy;
    logic [3:0] r1x, r1y, r2x, r2y;

    vt[0]  = '{4'd4,  4'd0,  4'd0,  4'd0,  4'd15, 4'd15, 40};
    vt[1]  = '{4'd0,  4'd4,  4'd0,  4'd0,  4'd15, 4'd15, 40};
    vt[2]  = '{4'd3,  4'd2,  4'd0,  4'd0,  4'd15, 4'd15, 40};
    vt[3]  = '{4'd3,  4'd3,  4'd0,  4'd0,  4'd15, 4'd15, 0};
    vt[4]  = '{4'd12, 4'd8,  4'd8,  4'd8,  4'd0,  4'd0,  40};
    vt[5]  = '{4'd4,  4'd8,  4'd8,  4'd8,  4'd0,  4'd0,  40};
    vt[6]  = '{4'd5,  4'd5,  4'd8,  4'd8,  4'd15, 4'd15, 0};
    vt[7]  = '{4'd15, 4'd15, 4'd0,  4'd0,  4'd15, 4'd11, 40};
    vt[8]  = '{4'd14, 4'd8,  4'd0,  4'd0,  4'd0,  4'd0,  0};
    vt[9]  = '{4'd0,  4'd0,  4'd2,  4'd0,  4'd15, 4'd15, 40};
    vt[10] = '{4'd9,  4'd9,  4'd10, 4'd10, 4'd10, 4'd10, 40};
    vt[11] = '{4'd15, 4'd6,  4'd0,  4'd0,  4'd0,  4'd15, 0};
    vt[12] = '{4'd0,  4'd0,  4'd15, 4'd15, 4'd15, 4'd15, 0};

    RST = 1'b1; IN_VALID = 1'b0; DONE_IN = 1'b0; X = '0; Y = '0;
    C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    repeat (3) @(negedge CLK);
    check("reset busy", int'(BUSY), 0);
    check("reset score", int'(SCORE), 0);
    check("reset score_valid", int'(SCORE_VALID), 0);
    RST = 1'b0;
    @(negedge CLK);

    // Single-point frames: each entry is 40 copies of one point.
    for (int i = 0; i < 13; i++) begin
      for (int j = 0; j < NPTS; j++) begin fx[j] = vt[i].px; fy[j] = vt[i].py; end
      send_points(0, NPTS - 1, 1'b0);
      finish_frame($sformatf("vec%0d", i), vt[i].c1x, vt[i].c1y, vt[i].c2x, vt[i].c2y,
                   vt[i].exp, -1, -1, 1'b0, 1'b0);
    end
    check_pulses("vectors");

    // All points at C1 centre; DONE_IN held high across REPORT and beyond.
    for (int j = 0; j < NPTS; j++) begin fx[j] = 4'd8; fy[j] = 4'd8; end
    send_points(0, NPTS - 1, 1'b1);
    finish_frame("t1", 4'd8, 4'd8, 4'd0, 4'd0, 40, 40, 0, 1'b0, 1'b1);
    repeat (50) @(negedge CLK);
    DONE_IN = 1'b0;
    check_pulses("t1 hold");

    // No coverage; junk point offered during REPORT must be ignored.
    for (int j = 0; j < NPTS; j++) begin fx[j] = 4'd0; fy[j] = 4'd0; end
    send_points(0, NPTS - 1, 1'b0);
    finish_frame("t2", 4'd15, 4'd15, 4'd15, 4'd0, 0, 0, 0, 1'b1, 1'b0);

    // Radius boundaries; starts the cycle right after REPORT.
    for (int j = 0; j < NPTS; j++) begin fx[j] = 4'd15; fy[j] = 4'd15; end
    fx[0] = 4'd4; fy[0] = 4'd0;
    fx[1] = 4'd3; fy[1] = 4'd2;
    fx[2] = 4'd3; fy[2] = 4'd3;
    fx[3] = 4'd0; fy[3] = 4'd4;
    fx[4] = 4'd2; fy[4] = 4'd3;
    send_points(0, NPTS - 1, 1'b0);
    finish_frame("t3", 4'd0, 4'd0, 4'd15, 4'd0, 4, 4, 0, 1'b0, 1'b0);
    check_pulses("t2_t3");

    // Overlapping circles: union counts each point once.
    for (int j = 0; j < NPTS; j++) begin fx[j] = (j < 20) ? 4'd5 : 4'd7; fy[j] = 4'd5; end
    send_points(0, NPTS - 1, 1'b1);
    finish_frame("t4", 4'd5, 4'd5, 4'd7, 4'd5, 40, 40, 40, 1'b0, 1'b0);

    // Early DONE_IN during CAPTURE is ignored.
    for (int j = 0; j < NPTS; j++) begin fx[j] = 4'(j % 16); fy[j] = 4'd8; end
    model(8, 8, 0, 0, s, n1, n2);
    send_points(0, NPTS - 2, 1'b0);
    DONE_IN = 1'b1; C1X = 4'd0; C1Y = 4'd0; C2X = 4'd0; C2Y = 4'd0;
    @(negedge CLK);
    DONE_IN = 1'b0;
    send_points(NPTS - 1, NPTS - 1, 1'b0);
    finish_frame("t5", 4'd8, 4'd8, 4'd0, 4'd0, s, n1, n2, 1'b0, 1'b0);
    check_pulses("t5");

    // Reset in the middle of EVAL.
    send_points(0, NPTS - 1, 1'b0);
    DONE_IN = 1'b1; C1X = 4'd8; C1Y = 4'd8; C2X = 4'd0; C2Y = 4'd0;
    @(negedge CLK);
    DONE_IN = 1'b0;
    repeat (20) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("t6 score_after_rst", int'(SCORE), 0);
    check("t6 busy_after_rst", int'(BUSY), 0);
    check("t6 valid_after_rst", int'(SCORE_VALID), 0);
    repeat (60) @(negedge CLK);
    check_pulses("t6 no_pulse");
    send_points(0, NPTS - 1, 1'b1);
    finish_frame("t6 next", 4'd8, 4'd8, 4'd0, 4'd0, s, n1, n2, 1'b0, 1'b0);

    // Random frames against the reference model.
    for (int f = 0; f < 12; f++) begin
      r1x = 4'($urandom); r1y = 4'($urandom); r2x = 4'($urandom); r2y = 4'($urandom);
      for (int j = 0; j < NPTS; j++) begin
        cx = ($urandom_range(0, 1) == 0) ? int'(r1x) : int'(r2x);
        cy = (cx == int'(r1x)) ? int'(r1y) : int'(r2y);
        cx = cx + int'($urandom_range(0, 10)) - 5;
        cy = cy + int'($urandom_range(0, 10)) - 5;
        cx = (cx < 0) ? 0 : (cx > 15) ? 15 : cx;
        cy = (cy < 0) ? 0 : (cy > 15) ? 15 : cy;
        fx[j] = 4'(cx); fy[j] = 4'(cy);
      end
      model(int'(r1x), int'(r1y), int'(r2x), int'(r2y), s, n1, n2);
      send_points(0, NPTS - 1, 1'b1);
      finish_frame($sformatf("rand%0d", f), r1x, r1y, r2x, r2y, s, n1, n2, 1'b0, 1'b0);
    end
    check_pulses("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
